// File: rtl/i2c_host_ctrl.sv
// i2c_host_ctrl: single-master I2C host running one register write or read (with repeated START)
// per command against a 7-bit device with an 8-bit memory address. No clock stretching or arbitration.
module i2c_host_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_adr,
  input  logic [7:0] cmd_mem_adr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic       rsp_nack,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam int unsigned QW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_TX     = 3'd2;
  localparam logic [2:0] S_RSTART = 3'd3;
  localparam logic [2:0] S_RX     = 3'd4;
  localparam logic [2:0] S_MNACK  = 3'd5;
  localparam logic [2:0] S_STOP   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic          rw_q, rw_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    mem_q, mem_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rx_q, rx_d;
  logic          ack_bad_q, ack_bad_d;
  logic          nack_q, nack_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_nack_q, rsp_nack_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic          scl_oe_q, scl_oe_d;
  logic          sda_oe_q, sda_oe_d;

  logic       tick;
  logic       sample;
  logic       slot_end;
  logic [7:0] tx_byte;
  logic       tx_bit;

  assign tick     = (qcnt_q == QLAST);
  assign sample   = tick && (qtr_q == 2'd2);
  assign slot_end = tick && (qtr_q == 2'd3);

  // Byte 2 is either the write data or, after the repeated START, the address with R set.
  always_comb begin
    case (byte_q)
      2'd0:    tx_byte = {dev_q, 1'b0};
      2'd1:    tx_byte = mem_q;
      default: tx_byte = rw_q ? {dev_q, 1'b1} : wdata_q;
    endcase
    tx_bit = tx_byte[3'd7 - bit_q[2:0]];
  end

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    mem_d     = mem_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    ack_bad_d = ack_bad_q;
    nack_d    = nack_q;

    if (state_q != S_IDLE && state_q != S_DONE) begin
      if (tick) begin
        qcnt_d = '0;
        qtr_d  = qtr_q + 2'd1;
      end else begin
        qcnt_d = qcnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d   = S_START;
          rw_d      = cmd_rw;
          dev_d     = cmd_dev_adr;
          mem_d     = cmd_mem_adr;
          wdata_d   = cmd_wdata;
          qcnt_d    = '0;
          qtr_d     = '0;
          bit_d     = '0;
          byte_d    = '0;
          rx_d      = '0;
          ack_bad_d = 1'b0;
          nack_d    = 1'b0;
        end
      end
      S_START: begin
        if (slot_end) begin
          state_d = S_TX;
          bit_d   = '0;
          byte_d  = 2'd0;
        end
      end
      S_TX: begin
        if (sample && bit_q[3]) ack_bad_d = sda_i;
        if (slot_end) begin
          if (!bit_q[3]) begin
            bit_d = bit_q + 4'd1;
          end else begin
            bit_d = '0;
            if (ack_bad_q) begin
              nack_d  = 1'b1;
              state_d = S_STOP;
            end else begin
              case (byte_q)
                2'd0: byte_d = 2'd1;
                2'd1: begin
                  if (rw_q) state_d = S_RSTART;
                  else      byte_d  = 2'd2;
                end
                default: state_d = rw_q ? S_RX : S_STOP;
              endcase
            end
          end
        end
      end
      S_RSTART: begin
        if (slot_end) begin
          state_d = S_TX;
          bit_d   = '0;
          byte_d  = 2'd2;
        end
      end
      S_RX: begin
        if (sample) rx_d = {rx_q[6:0], sda_i};
        if (slot_end) begin
          if (bit_q == 4'd7) begin
            bit_d   = '0;
            state_d = S_MNACK;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_MNACK: if (slot_end) state_d = S_STOP;
      S_STOP:  if (slot_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_d = (state_q == S_STOP) && slot_end;
    rsp_nack_d  = rsp_nack_q;
    rsp_rdata_d = rsp_rdata_q;
    if (rsp_valid_d) begin
      rsp_nack_d  = nack_q;
      rsp_rdata_d = (nack_q || !rw_q) ? 8'h00 : rx_q;
    end
  end

  // Pad enables are registered, so the bus trails the quarter counter by one clk throughout.
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_q)
      S_START: begin
        scl_oe_d = (qtr_q == 2'd3);
        sda_oe_d = (qtr_q != 2'd0);
      end
      S_RSTART: begin
        scl_oe_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sda_oe_d = qtr_q[1];
      end
      S_TX: begin
        scl_oe_d = !qtr_q[1];
        sda_oe_d = !bit_q[3] && !tx_bit;
      end
      S_RX, S_MNACK: begin
        scl_oe_d = !qtr_q[1];
      end
      S_STOP: begin
        scl_oe_d = (qtr_q == 2'd0);
        sda_oe_d = !qtr_q[1];
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      qcnt_q      <= '0;
      qtr_q       <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      rw_q        <= 1'b0;
      dev_q       <= '0;
      mem_q       <= '0;
      wdata_q     <= '0;
      rx_q        <= '0;
      ack_bad_q   <= 1'b0;
      nack_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_nack_q  <= 1'b0;
      rsp_rdata_q <= '0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      mem_q       <= mem_d;
      wdata_q     <= wdata_d;
      rx_q        <= rx_d;
      ack_bad_q   <= ack_bad_d;
      nack_q      <= nack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_nack_q  <= rsp_nack_d;
      rsp_rdata_q <= rsp_rdata_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_nack  = rsp_nack_q;
  assign rsp_rdata = rsp_rdata_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule
